// File: rtl/ctm_pkg.sv
// rtl/ctm_pkg.sv - shared types and constants for the CTM model loader
//
// Purpose : loader FSM state encoding and stream/line geometry.
// Ports   : none (package).
// Config  : CTM_LOADER_CHECKSUM_EN selects whether ST_CHK is reachable.

package ctm_pkg;

  localparam int LINE_W         = 256;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = LINE_W / WORD_W;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_CLAUSE = 3'd2,
    ST_WEIGHT = 3'd3,
    ST_CHK    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

endpackage

// File: rtl/ctm_line_packer.sv
// rtl/ctm_line_packer.sv - packs eight 32-bit beats into one 256-bit line
//
// Purpose : beat counter plus accumulator shared by the clause and weight
//           phases. Word k of a line lands in bits [32k+31:32k].
// Ports   : clk, reset      clock / synchronous active-high reset
//           i_clear         drop any partial line and restart at word 0
//           i_beat, i_word  accepted stream word
//           o_line          completed line, valid only while o_line_done=1
//           o_line_done     pulses in the cycle the 8th word is accepted

module ctm_line_packer
  import ctm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_beat,
  input  logic [WORD_W-1:0] i_word,
  output logic [LINE_W-1:0] o_line,
  output logic              o_line_done
);

  logic [2:0]        r_cnt;
  logic [LINE_W-1:0] r_acc;
  logic [7:0]        w_bit_idx;

  assign w_bit_idx = {r_cnt, 5'b00000};

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (i_beat) begin
      r_acc[w_bit_idx +: WORD_W] <= i_word;
      r_cnt                      <= r_cnt + 3'd1;
    end
  end

  assign o_line_done = i_beat && (r_cnt == 3'd7);

  // The last word bypasses the accumulator so the full line is available
  // in the same cycle as the final beat; the top registers it next edge.
  assign o_line = {i_word, r_acc[LINE_W-WORD_W-1:0]};

endmodule

// File: rtl/ctm_model_loader.sv
// rtl/ctm_model_loader.sv - streams a CTM model into the clause and weight BRAMs
//
// Purpose : consumes header, clause lines and weight lines from a 32-bit
//           valid/ready stream and issues one-cycle BRAM write strobes.
// Ports   : clk, reset                       clock / sync active-high reset
//           start                            arm loader (IDLE/DONE/ERR only)
//           s_data, s_valid, s_ready         input stream
//           clause_wr_en/addr/data           clause BRAM write port
//           weight_wr_en/addr/data           weight BRAM write port
//           clauses_cfg                      clause count from header
//           model_ready, load_err            status levels
// Config  : CTM_LOADER_CHECKSUM_EN adds a trailing 32-bit wrap-around sum
//           beat after the weights, checked before declaring DONE.

module ctm_model_loader
  import ctm_pkg::*;
#(
  parameter int CLAUSEN      = 10,
  parameter int CLASSN       = 10,
  parameter int WL_PER_CLASS = 5,
  parameter int WADDR_W      = $clog2(CLASSN*WL_PER_CLASS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic               clause_wr_en,
  output logic [31:0]        clause_addr,
  output logic [LINE_W-1:0]  clause_data,
  output logic               weight_wr_en,
  output logic [WADDR_W-1:0] weight_addr,
  output logic [LINE_W-1:0]  weight_data,
  output logic [8:0]         clauses_cfg,
  output logic               model_ready,
  output logic               load_err
);

  localparam logic [WADDR_W-1:0] LAST_WLINE = WADDR_W'(CLASSN*WL_PER_CLASS-1);
  localparam logic [8:0]         MAX_N      = 9'(CLAUSEN);

  state_t              r_state, w_next;
  logic [8:0]          r_cline;
  logic [WADDR_W-1:0]  r_wline;
  logic                r_clause_wr_en, r_weight_wr_en;
  logic [31:0]         r_clause_addr;
  logic [WADDR_W-1:0]  r_weight_addr;
  logic [LINE_W-1:0]   r_clause_data, r_weight_data;
  logic [8:0]          r_clauses_cfg;

  logic                w_beat, w_start_ok, w_hdr_bad, w_pack_beat;
  logic                w_line_done, w_last_cline, w_last_wline;
  logic [LINE_W-1:0]   w_line;
  logic [8:0]          w_hdr_n;

`ifdef CTM_LOADER_CHECKSUM_EN
  logic [31:0]         r_sum;
`endif

  assign s_ready = (r_state == ST_HDR)    || (r_state == ST_CLAUSE) ||
                   (r_state == ST_WEIGHT) || (r_state == ST_CHK);
  assign w_beat      = s_valid && s_ready;
  assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                 (r_state == ST_ERR));
  assign w_hdr_n     = s_data[8:0];
  assign w_hdr_bad   = (w_hdr_n == 9'd0) || (w_hdr_n > MAX_N);
  assign w_pack_beat = w_beat && ((r_state == ST_CLAUSE) || (r_state == ST_WEIGHT));
  assign w_last_cline = (r_cline == r_clauses_cfg - 9'd1);
  assign w_last_wline = (r_wline == LAST_WLINE);

  ctm_line_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_start_ok),
    .i_beat      (w_pack_beat),
    .i_word      (s_data),
    .o_line      (w_line),
    .o_line_done (w_line_done)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: if (start) w_next = ST_HDR;
      ST_HDR:    if (w_beat) w_next = w_hdr_bad ? ST_ERR : ST_CLAUSE;
      ST_CLAUSE: if (w_line_done && w_last_cline) w_next = ST_WEIGHT;
`ifdef CTM_LOADER_CHECKSUM_EN
      ST_WEIGHT: if (w_line_done && w_last_wline) w_next = ST_CHK;
      ST_CHK:    if (w_beat) w_next = (s_data == r_sum) ? ST_DONE : ST_ERR;
`else
      ST_WEIGHT: if (w_line_done && w_last_wline) w_next = ST_DONE;
`endif
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cline        <= '0;
      r_wline        <= '0;
      r_clause_wr_en <= 1'b0;
      r_weight_wr_en <= 1'b0;
      r_clause_addr  <= '0;
      r_weight_addr  <= '0;
      r_clause_data  <= '0;
      r_weight_data  <= '0;
      r_clauses_cfg  <= '0;
    end else begin
      r_clause_wr_en <= 1'b0;
      r_weight_wr_en <= 1'b0;
      if (w_start_ok) begin
        r_cline <= '0;
        r_wline <= '0;
      end
      if ((r_state == ST_HDR) && w_beat && !w_hdr_bad)
        r_clauses_cfg <= w_hdr_n;
      if ((r_state == ST_CLAUSE) && w_line_done) begin
        r_clause_wr_en <= 1'b1;
        r_clause_addr  <= 32'(r_cline);
        r_clause_data  <= w_line;
        r_cline        <= w_last_cline ? 9'd0 : r_cline + 9'd1;
      end
      if ((r_state == ST_WEIGHT) && w_line_done) begin
        r_weight_wr_en <= 1'b1;
        r_weight_addr  <= r_wline;
        r_weight_data  <= w_line;
        r_wline        <= w_last_wline ? '0 : r_wline + 1'b1;
      end
    end
  end

`ifdef CTM_LOADER_CHECKSUM_EN
  // Sum covers every beat before the checksum itself, header included.
  always_ff @(posedge clk) begin
    if (reset || w_start_ok) r_sum <= '0;
    else if (w_beat && (r_state != ST_CHK)) r_sum <= r_sum + s_data;
  end
`endif

  assign clause_wr_en = r_clause_wr_en;
  assign clause_addr  = r_clause_addr;
  assign clause_data  = r_clause_data;
  assign weight_wr_en = r_weight_wr_en;
  assign weight_addr  = r_weight_addr;
  assign weight_data  = r_weight_data;
  assign clauses_cfg  = r_clauses_cfg;
  assign model_ready  = (r_state == ST_DONE);
  assign load_err     = (r_state == ST_ERR);

endmodule

// File: tb/tb_ctm_model_loader.sv
// tb/tb_ctm_model_loader.sv - scoreboard bench for ctm_model_loader

module tb_ctm_model_loader;

  logic         clk = 1'b0;
  logic         reset, start, s_valid, s_ready;
  logic [31:0]  s_data;
  logic         clause_wr_en, weight_wr_en, model_ready, load_err;
  logic [31:0]  clause_addr;
  logic [255:0] clause_data, weight_data;
  logic [5:0]   weight_addr;
  logic [8:0]   clauses_cfg;

  typedef struct packed {
    logic [31:0]  a;
    logic [255:0] d;
  } wr_t;

  wr_t         cq[$];
  wr_t         wq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_cw    = 0;
  int          n_ww    = 0;
  logic [31:0] exp_sum;

  always #5 clk = ~clk;

  ctm_model_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .clause_wr_en (clause_wr_en),
    .clause_addr  (clause_addr),
    .clause_data  (clause_data),
    .weight_wr_en (weight_wr_en),
    .weight_addr  (weight_addr),
    .weight_data  (weight_data),
    .clauses_cfg  (clauses_cfg),
    .model_ready  (model_ready),
    .load_err     (load_err)
  );

  // Monitor: pops the scoreboard whenever a write strobe is presented.
  always @(negedge clk) begin
    if (!reset) begin
      if (clause_wr_en && weight_wr_en) begin
        n_tests++; n_fail++;
        $display("FAIL both_strobes: clause and weight strobes together");
      end
      if (clause_wr_en) begin
        wr_t e;
        n_cw++;
        n_tests++;
        if (cq.size() == 0) begin
          n_fail++;
          $display("FAIL clause_unexpected: addr=%0d with empty queue", clause_addr);
        end else begin
          e = cq.pop_front();
          if (clause_addr != e.a || clause_data != e.d) begin
            n_fail++;
            $display("FAIL clause_wr: got addr=%0d data=%h exp addr=%0d data=%h",
                     clause_addr, clause_data, e.a, e.d);
          end
        end
      end
      if (weight_wr_en) begin
        wr_t e;
        n_ww++;
        n_tests++;
        if (wq.size() == 0) begin
          n_fail++;
          $display("FAIL weight_unexpected: addr=%0d with empty queue", weight_addr);
        end else begin
          e = wq.pop_front();
          if (32'(weight_addr) != e.a || weight_data != e.d) begin
            n_fail++;
            $display("FAIL weight_wr: got addr=%0d data=%h exp addr=%0d data=%h",
                     weight_addr, weight_data, e.a, e.d);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", name, act, exp);
    end
  endtask

  // Present one word and hold it until accepted; returns #1 after the edge.
  task automatic send(input logic [31:0] w);
    int t = 0;
    @(negedge clk);
    s_data  = w;
    s_valid = 1'b1;
    while (!s_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: s_ready=%0b exp 1", s_ready);
    end
    @(posedge clk);
    #1;
    exp_sum = exp_sum + w;
  endtask

  task automatic bubble();
    @(negedge clk);
    s_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    exp_sum = '0;
  endtask

  // Sends nlines lines of words base+8l+k; start_at pulses start alongside that word.
  task automatic send_lines(input int nlines, input logic [31:0] base, input bit is_clause,
                            input bit gaps, input int start_at);
    for (int l = 0; l < nlines; l++) begin
      logic [255:0] line = '0;
      for (int k = 0; k < 8; k++) begin
        logic [31:0] w = base + 32'(l*8 + k);
        line[32*k +: 32] = w;
        if (k == 7) begin
          if (is_clause) cq.push_back('{a: 32'(l), d: line});
          else           wq.push_back('{a: 32'(l), d: line});
        end
        if (gaps) bubble();
        if (start_at == l*8 + k) start = 1'b1;
        send(w);
        start = 1'b0;
      end
    end
  endtask

  task automatic full_load(input int n, input bit gaps, input int start_at, input int chk_delta);
    int ww0 = n_ww;
    int cw0 = n_cw;
    do_start();
    chk("hdr_ready", {255'd0, s_ready}, 256'd1);
    send(32'(n));
    send_lines(n, 32'd1, 1'b1, gaps, -1);
    send_lines(50, 32'hA000_0000, 1'b0, 1'b0, start_at);
`ifdef CTM_LOADER_CHECKSUM_EN
    chk("pre_chk_ready", {255'd0, model_ready}, 256'd0);
    send(exp_sum + 32'(chk_delta));
`endif
    idle(4);
    chk("clause_strobes", 256'(n_cw - cw0), 256'(n));
    chk("weight_strobes", 256'(n_ww - ww0), 256'd50);
    chk("queues_empty", 256'(cq.size() + wq.size()), 256'd0);
    chk("clauses_cfg", {247'd0, clauses_cfg}, 256'(n));
    chk("s_ready_end", {255'd0, s_ready}, 256'd0);
    chk("clause_addr_hold", {224'd0, clause_addr}, 256'(n - 1));
    chk("weight_addr_hold", {250'd0, weight_addr}, 256'd49);
    if (chk_delta == 0) begin
      chk("model_ready", {255'd0, model_ready}, 256'd1);
      chk("load_err", {255'd0, load_err}, 256'd0);
    end else begin
      chk("model_ready_bad", {255'd0, model_ready}, 256'd0);
      chk("load_err_bad", {255'd0, load_err}, 256'd1);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ready"},      {255'd0, s_ready},      256'd0);
    chk({tag, "_clause_wr_en"}, {255'd0, clause_wr_en}, 256'd0);
    chk({tag, "_clause_addr"},  {224'd0, clause_addr},  256'd0);
    chk({tag, "_clause_data"},  clause_data,            256'd0);
    chk({tag, "_weight_wr_en"}, {255'd0, weight_wr_en}, 256'd0);
    chk({tag, "_weight_addr"},  {250'd0, weight_addr},  256'd0);
    chk({tag, "_weight_data"},  weight_data,            256'd0);
    chk({tag, "_clauses_cfg"},  {247'd0, clauses_cfg},  256'd0);
    chk({tag, "_model_ready"},  {255'd0, model_ready},  256'd0);
    chk({tag, "_load_err"},     {255'd0, load_err},     256'd0);
  endtask

  task automatic bad_header(input logic [31:0] n);
    int w0 = n_cw + n_ww;
    do_start();
    chk("bad_hdr_armed", {254'd0, s_ready, load_err}, 256'd2);
    send(n);
    idle(3);
    chk("bad_hdr_err", {255'd0, load_err}, 256'd1);
    chk("bad_hdr_ready", {255'd0, s_ready}, 256'd0);
    chk("bad_hdr_mr", {255'd0, model_ready}, 256'd0);
    chk("bad_hdr_cfg", {247'd0, clauses_cfg}, 256'd3);
    chk("bad_hdr_strobes", 256'(n_cw + n_ww - w0), 256'd0);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    exp_sum = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_all_zero("reset");

    // s_valid while not ready must be ignored
    s_valid = 1'b1; s_data = 32'h3;
    idle(0);
    repeat (2) @(posedge clk);
    #1;
    s_valid = 1'b0;
    chk("idle_ignore_cfg", {247'd0, clauses_cfg}, 256'd0);

    // Gap-free load of 3 clauses; line0 = words 1..8
    full_load(3, 1'b0, -1, 0);

    // Header errors, then re-arm
    bad_header(32'd0);
    bad_header(32'd11);
    do_start();
    chk("rearm_hdr", {254'd0, s_ready, load_err}, 256'd2);

    // Toggling valid during clause phase (start from HDR: start ignored there)
    send(32'd3);
    send_lines(3, 32'd1, 1'b1, 1'b1, -1);
    send_lines(50, 32'hA000_0000, 1'b0, 1'b0, -1);
`ifdef CTM_LOADER_CHECKSUM_EN
    send(exp_sum);
`endif
    idle(4);
    chk("gap_model_ready", {255'd0, model_ready}, 256'd1);
    chk("gap_queues_empty", 256'(cq.size() + wq.size()), 256'd0);

    // Gap load via full_load too
    full_load(3, 1'b1, -1, 0);

    // Start pulsed mid-weight is ignored
    full_load(2, 1'b0, 100, 0);

`ifdef CTM_LOADER_CHECKSUM_EN
    full_load(2, 1'b0, -1, 1);
`endif

    // Reset after 5 beats of clause line 1
    do_start();
    send(32'd2);
    begin
      logic [255:0] line = '0;
      for (int k = 0; k < 8; k++) line[32*k +: 32] = 32'(k + 1);
      cq.push_back('{a: 32'd0, d: line});
    end
    for (int k = 0; k < 8; k++) send(32'(k + 1));
    for (int k = 0; k < 5; k++) send(32'(k + 9));
    s_valid = 1'b0;
    reset   = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_all_zero("midreset");
    idle(10);
    chk("midreset_queue", 256'(cq.size()), 256'd0);
    chk("midreset_idle_ready", {255'd0, s_ready}, 256'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
